// File: rtl/video_scanout.sv
// video_scanout: pixel-clock raster timing generator with framebuffer scan-out.
// Produces hsync/vsync/de and 24-bit RGB for the DVI stage. It fetches 1-bpp
// bytes plus an IRGB attribute from column-organised VRAM and shows the
// 384x256 image doubled to 768x512 inside a border. All outputs are registered
// and appear one pclk after the counter state they describe.
// Optional build macro VIDEO_SCANLINES_EN: halves fg/bg components on odd
// window lines.
module video_scanout #(
   parameter int          H_ACTIVE   = 1024,
   parameter int          H_FP       = 24,
   parameter int          H_SYNC     = 136,
   parameter int          H_BP       = 144,
   parameter int          V_ACTIVE   = 768,
   parameter int          V_FP       = 3,
   parameter int          V_SYNC     = 6,
   parameter int          V_BP       = 29,
   parameter bit          SYNC_POL   = 1'b0,
   parameter int          WIN_X0     = 128,
   parameter int          WIN_Y0     = 128,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input  logic        pclk,
   input  logic        reset,
   output logic        vram_rd,
   output logic [13:0] vram_addr,
   input  logic [7:0]  vram_data,
   input  logic [3:0]  vram_attr,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  red_data,
   output logic [7:0]  green_data,
   output logic [7:0]  blue_data,
   output logic        frame_start
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST = 12'(HT - 1);
   localparam logic [11:0] V_LAST = 12'(VT - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] WX0    = 12'(WIN_X0);
   localparam logic [11:0] WY0    = 12'(WIN_Y0);
   localparam logic [11:0] WIN_W  = 12'd768;
   localparam logic [11:0] WIN_H  = 12'd512;

   logic [11:0] hcnt, vcnt;
   logic [11:0] h_nxt, v_nxt;
   logic [11:0] wx, wy, wy_nxt, fx_nxt;
   logic        h_act, v_act, active, win_line, in_win;
   logic        fetch_nxt;

   logic        rd_d1;
   logic [7:0]  hold_data, shift_data;
   logic [3:0]  hold_attr, shift_attr;

   logic        pix_bit;
   logic [3:0]  pix_attr;
   logic [23:0] pix_rgb;

   function automatic logic [7:0] comp_level(input logic on, input logic inten);
      if (on)
         comp_level = inten ? 8'hFF : 8'hAA;
      else
         comp_level = inten ? 8'h55 : 8'h00;
   endfunction

   // Next counter state; the fetch strobe is decided one cycle ahead from it
   // so vram_rd is visible exactly at column WIN_X0+16k-2, even across a line wrap.
   always_comb begin
      h_nxt = hcnt + 12'd1;
      v_nxt = vcnt;
      if (hcnt == H_LAST) begin
         h_nxt = 12'd0;
         v_nxt = (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
      end
      wx        = hcnt - WX0;
      wy        = vcnt - WY0;
      wy_nxt    = v_nxt - WY0;
      fx_nxt    = h_nxt + 12'd2 - WX0;
      h_act     = hcnt < H_ACT;
      v_act     = vcnt < V_ACT;
      active    = h_act & v_act;
      win_line  = (wy < WIN_H) & v_act;
      in_win    = win_line & h_act & (wx < WIN_W);
      fetch_nxt = (wy_nxt < WIN_H) & (v_nxt < V_ACT) & (fx_nxt < WIN_W)
                  & (fx_nxt[3:0] == 4'd0);
   end

   // Current pixel: on the first column of a byte the shifter has not loaded
   // yet, so the holding register supplies the leftmost bit directly.
   always_comb begin
      pix_bit  = (wx[3:0] == 4'd0) ? hold_data[7] : shift_data[7];
      pix_attr = (wx[3:0] == 4'd0) ? hold_attr : shift_attr;
      pix_rgb  = 24'h000000;
      if (pix_bit)
         pix_rgb = {comp_level(pix_attr[2], pix_attr[3]),
                    comp_level(pix_attr[1], pix_attr[3]),
                    comp_level(pix_attr[0], pix_attr[3])};
`ifdef VIDEO_SCANLINES_EN
      if (wy[0])
         pix_rgb = {1'b0, pix_rgb[23:17], 1'b0, pix_rgb[15:9], 1'b0, pix_rgb[7:1]};
`endif
   end

   // Raster counters; both wrap together at the last pixel of the frame.
   always_ff @(posedge pclk) begin
      if (reset) begin
         hcnt <= 12'd0;
         vcnt <= 12'd0;
      end else begin
         hcnt <= h_nxt;
         vcnt <= v_nxt;
      end
   end

   // VRAM read strobe/address, and capture of the returned byte one cycle later.
   always_ff @(posedge pclk) begin
      if (reset) begin
         vram_rd   <= 1'b0;
         vram_addr <= 14'd0;
         rd_d1     <= 1'b0;
         hold_data <= 8'h00;
         hold_attr <= 4'h0;
      end else begin
         vram_rd <= fetch_nxt;
         rd_d1   <= vram_rd;
         if (fetch_nxt)
            vram_addr <= {fx_nxt[9:4], wy_nxt[8:1]};
         if (rd_d1) begin
            hold_data <= vram_data;
            hold_attr <= vram_attr;
         end
      end
   end

   // Pixel shifter: load at each byte boundary, advance every second pixel.
   always_ff @(posedge pclk) begin
      if (reset) begin
         shift_data <= 8'h00;
         shift_attr <= 4'h0;
      end else if (in_win) begin
         if (wx[3:0] == 4'd0) begin
            shift_data <= hold_data;
            shift_attr <= hold_attr;
         end else if (wx[0]) begin
            shift_data <= {shift_data[6:0], 1'b0};
         end
      end
   end

   // Registered video outputs, all describing the same counter state.
   always_ff @(posedge pclk) begin
      if (reset) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         red_data    <= 8'h00;
         green_data  <= 8'h00;
         blue_data   <= 8'h00;
         frame_start <= 1'b0;
      end else begin
         hsync       <= ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vsync       <= ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
         de          <= active;
         frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
         if (!active)
            {red_data, green_data, blue_data} <= 24'h000000;
         else if (in_win)
            {red_data, green_data, blue_data} <= pix_rgb;
         else
            {red_data, green_data, blue_data} <= BORDER_RGB;
      end
   end

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout. Vertical timing and window origin are
// shrunk so several window lines and a full frame fit in a short run;
// horizontal timing stays at the default 1328-pixel line.
module tb_video_scanout;

   localparam int HT  = 1328;
   localparam int VT  = 13;   // 8 active + 1 fp + 2 sync + 2 bp

`ifdef VIDEO_SCANLINES_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        reset = 1'b1;
   logic        vram_rd;
   logic [13:0] vram_addr;
   logic [7:0]  vram_data = 8'h00;
   logic [3:0]  vram_attr = 4'h0;
   logic        hsync, vsync, de, frame_start;
   logic [7:0]  red_data, green_data, blue_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hn, vn, hp, vp;
   int rd_cnt [0:VT-1];
   int de_cnt [0:VT-1];
   int fs_cnt = 0;
   int first_h2 = -1, last_h2 = -1;
   logic [13:0] first_a2 = '0, last_a2 = '0, first_a4 = '1;

   video_scanout #(
      .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(144),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b0), .WIN_X0(128), .WIN_Y0(2),
      .BORDER_RGB(24'h123456)
   ) dut (
      .pclk(pclk), .reset(reset),
      .vram_rd(vram_rd), .vram_addr(vram_addr),
      .vram_data(vram_data), .vram_attr(vram_attr),
      .hsync(hsync), .vsync(vsync), .de(de),
      .red_data(red_data), .green_data(green_data), .blue_data(blue_data),
      .frame_start(frame_start)
   );

   always #5 pclk = ~pclk;

   // VRAM model: {attr,data} for {byte_col, row}, returned the cycle after the strobe.
   function automatic logic [11:0] mem(input logic [13:0] a);
      case (a)
         {6'd0,  8'd0}: mem = {4'b0100, 8'h80};
         {6'd1,  8'd0}: mem = {4'b1010, 8'h41};
         {6'd47, 8'd0}: mem = {4'b0111, 8'h01};
         {6'd0,  8'd1}: mem = {4'b1111, 8'hFF};
         default:       mem = 12'h000;
      endcase
   endfunction

   always @(posedge pclk)
      if (vram_rd) {vram_attr, vram_data} <= mem(vram_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      @(negedge pclk);
      cyc++;
      hn = cyc % HT;
      vn = (cyc / HT) % VT;
      hp = (cyc - 1) % HT;
      vp = ((cyc - 1) / HT) % VT;
   endtask

   function automatic logic [23:0] rgb();
      rgb = {red_data, green_data, blue_data};
   endfunction

   initial begin
      for (int i = 0; i < VT; i++) begin
         rd_cnt[i] = 0;
         de_cnt[i] = 0;
      end

      // Reset state
      repeat (3) tick();
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_rgb", 32'(rgb()), 32'h000000);
      chk("rst_rd", 32'(vram_rd), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);

      reset = 1'b0;
      cyc = 0;

      // Lines 0..5: sync timing, border/blank, fetch pattern, pixel pipeline
      while (cyc < 6 * HT + 2) begin
         tick();
         if (frame_start) fs_cnt++;
         if (de) de_cnt[vp]++;
         if (vram_rd) begin
            rd_cnt[vn]++;
            if (vn == 2) begin
               if (first_h2 < 0) begin
                  first_h2 = hn;
                  first_a2 = vram_addr;
               end
               last_h2 = hn;
               last_a2 = vram_addr;
            end
            if (vn == 4 && rd_cnt[4] == 1) first_a4 = vram_addr;
         end
         if (cyc == 1)    chk("fs_first", 32'(frame_start), 32'd1);
         if (cyc == 2)    chk("fs_once", 32'(frame_start), 32'd0);
         if (cyc == 1048) chk("hs_before", 32'(hsync), 32'd1);
         if (cyc == 1049) chk("hs_edge", 32'(hsync), 32'd0);
         if (cyc == 1184) chk("hs_last", 32'(hsync), 32'd0);
         if (cyc == 1185) chk("hs_end", 32'(hsync), 32'd1);
         if (vp == 0 && hp == 10) begin
            chk("border_de", 32'(de), 32'd1);
            chk("border_rgb", 32'(rgb()), 32'h123456);
         end
         if (vp == 0 && hp == 1100) begin
            chk("blank_de", 32'(de), 32'd0);
            chk("blank_rgb", 32'(rgb()), 32'h000000);
         end
         if (vp == 2) begin
            if (hp == 127) chk("l2_left_border", 32'(rgb()), 32'h123456);
            if (hp == 128 || hp == 129) chk("l2_k0_bit7", 32'(rgb()), 32'hAA0000);
            if (hp >= 130 && hp <= 143) chk("l2_k0_zero", 32'(rgb()), 32'h000000);
            if (hp == 144) chk("l2_k1_bit7", 32'(rgb()), 32'h000000);
            if (hp == 146 || hp == 147) chk("l2_k1_bit6", 32'(rgb()), 32'h55FF55);
            if (hp == 158 || hp == 159) chk("l2_k1_bit0", 32'(rgb()), 32'h55FF55);
            if (hp == 895) chk("l2_k47_bit0", 32'(rgb()), 32'hAAAAAA);
            if (hp == 896) chk("l2_right_border", 32'(rgb()), 32'h123456);
         end
         if (vp == 3) begin
            if (hp == 128) chk("l3_k0_bit7", 32'(rgb()), SCAN ? 32'h550000 : 32'hAA0000);
            if (hp == 146) chk("l3_k1_bit6", 32'(rgb()), SCAN ? 32'h2A7F2A : 32'h55FF55);
         end
         if (vp == 4 && hp == 128) chk("l4_white", 32'(rgb()), 32'hFFFFFF);
         if (vp == 5 && hp == 128) chk("l5_white", 32'(rgb()), SCAN ? 32'h7F7F7F : 32'hFFFFFF);
      end

      chk("rd_cnt_line1", 32'(rd_cnt[1]), 32'd0);
      chk("rd_cnt_line2", 32'(rd_cnt[2]), 32'd48);
      chk("rd_cnt_line4", 32'(rd_cnt[4]), 32'd48);
      chk("rd_first_h", 32'(first_h2), 32'd126);
      chk("rd_first_addr", 32'(first_a2), 32'h0000);
      chk("rd_last_h", 32'(last_h2), 32'd878);
      chk("rd_last_addr", 32'(last_a2), 32'h2F00);
      chk("rd_line4_addr", 32'(first_a4), 32'h0001);
      chk("de_cnt_line2", 32'(de_cnt[2]), 32'd1024);
      chk("fs_count", 32'(fs_cnt), 32'd1);

      // Vertical sync window and frame wrap
      while (cyc < VT * HT + 1) begin
         tick();
         if (cyc == 9 * HT)      chk("vs_before", 32'(vsync), 32'd1);
         if (cyc == 9 * HT + 1)  chk("vs_edge", 32'(vsync), 32'd0);
         if (cyc == 11 * HT)     chk("vs_last", 32'(vsync), 32'd0);
         if (cyc == 11 * HT + 1) chk("vs_end", 32'(vsync), 32'd1);
         if (cyc == VT * HT)     chk("fs_pre_wrap", 32'(frame_start), 32'd0);
         if (cyc == VT * HT + 1) chk("fs_wrap", 32'(frame_start), 32'd1);
      end

      // Mid-frame reset at vcnt=6, hcnt=509 (a fetch and active pixel would follow)
      while (cyc < VT * HT + 6 * HT + 509) tick();
      chk("pre_rst_de", 32'(de), 32'd1);
      reset = 1'b1;
      tick();
      chk("midrst_hsync", 32'(hsync), 32'd1);
      chk("midrst_vsync", 32'(vsync), 32'd1);
      chk("midrst_de", 32'(de), 32'd0);
      chk("midrst_rd", 32'(vram_rd), 32'd0);
      chk("midrst_rgb", 32'(rgb()), 32'h000000);
      reset = 1'b0;
      cyc = 0;
      tick();
      chk("midrst_fs", 32'(frame_start), 32'd1);
      while (cyc < 11) tick();
      chk("midrst_border_de", 32'(de), 32'd1);
      chk("midrst_border_rgb", 32'(rgb()), 32'h123456);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
